vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates raster timing for the VGA controller: horizontal and vertical pixel counters, active-low sync pulses, a visible-area flag and a frame-start strobe.
- Drives the hcount/vcount buses consumed by the draw/region-decode logic, and hsync/vsync to the DAC connector.
- Default timing is 640x480 @ 60 Hz (800 x 525 total) from a 25 MHz pixel rate.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)

Ports:
- clk, input, 1, system clock (50 MHz with divider, 25 MHz without)
- reset, input, 1, asynchronous active-low reset
- pix_tick, output, 1, pixel enable; counters advance only when high
- hcount, output, 10, horizontal position, 0..H_TOTAL-1
- vcount, output, 10, vertical position, 0..V_TOTAL-1
- hsync, output, 1, horizontal sync, active low
- vsync, output, 1, vertical sync, active low
- video_on, output, 1, high while (hcount,vcount) is in the visible area
- frame_start, output, 1, one-clk pulse when the counters wrap to (0,0)

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both must be ≤ 1024; counters are 10-bit unsigned.
- Reset (reset=0, async):
  - hcount=0, vcount=0, hsync=1, vsync=1, video_on=0, frame_start=0, pix_tick=0.
  - The divider state clears.
- Horizontal counter, on a clk edge with pix_tick=1:
  - hcount=H_TOTAL-1 → 0; otherwise hcount+1.
- Vertical counter:
  - Increments only on the tick where hcount wraps.
  - vcount=V_TOTAL-1 at that wrap → 0.
- hsync, vsync and video_on are registered and update on the same tick as the counters. They are decoded from the new counter values, so they are always cycle-aligned with hcount/vcount (zero relative latency).
  - hsync=0 iff H_VISIBLE+H_FRONT ≤ hcount < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vsync=0 iff V_VISIBLE+V_FRONT ≤ vcount < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
  - video_on=1 iff hcount < H_VISIBLE and vcount < V_VISIBLE.
- frame_start:
  - High for exactly one clk: the cycle following the tick that moved the counters from (H_TOTAL-1, V_TOTAL-1) to (0,0).
  - Low at all other times, including after reset release (the reset state of (0,0) is not a wrap).
- Between ticks, all outputs hold their values.
- Reset asserted mid-frame: immediate return to the reset values. After release, counting restarts from (0,0) on the next tick; no partial-frame frame_start is generated.

Optional Feature:
- Macro: VGA_PIX_DIV_EN.
- Defined:
  - An internal 1-bit divider toggles every clk; pix_tick = divider==1.
  - pix_tick is high on every 2nd clk. The first high clk is the 2nd rising edge after reset release.
  - Counters therefore advance every 2 clk (50 MHz in, 25 MHz pixel).
- Undefined:
  - No divider; pix_tick=1 whenever reset=1 (0 during reset).
  - Counters advance every clk.

Test Plan:
- Reset, with macro undefined: hold reset=0 for 3 clk → hcount=0, vcount=0, hsync=1, vsync=1, video_on=0, frame_start=0. Release → after 1 clk hcount=1, video_on=1.
- Line timing, macro undefined: count clks from release →
  - video_on falls when hcount=640;
  - hsync=0 exactly for hcount 656..751 (96 clks);
  - hcount 799→0 with vcount 0→1 at clk 800.
- Frame timing:
  - vsync=0 exactly while vcount is 490..491 (1600 clks);
  - video_on stays 0 for vcount 480..524;
  - wrap (799,524)→(0,0) raises frame_start for exactly 1 clk, at clk 420000 after release.
- Divider, macro defined: pix_tick pattern 0,1,0,1 from release; hcount reaches 640 after 1280 clks; frame_start period is 840000 clks.
- Mid-frame reset: assert reset=0 at hcount=700, vcount=300 (hsync=0) → all outputs return to reset values asynchronously, before the next clk edge. After release, the sequence restarts from hcount=1, vcount=0 and no frame_start pulse appears.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v pixel counters, active-low syncs, visible flag, frame-start strobe.
// Define VGA_PIX_DIV_EN to derive the pixel enable from a divide-by-2 of clk; otherwise every clk is a pixel.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_start
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       frame_start_q, frame_start_d;

`ifdef VGA_PIX_DIV_EN
  logic div_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= 1'b0;
    end else begin
      div_q <= ~div_q;
    end
  end

  assign pix_tick = div_q;
`else
  assign pix_tick = reset;
`endif

  // Syncs and video_on are decoded from the next counter values so they stay aligned with the counters.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      if (hcount_q == H_LAST) begin
        hcount_d = 10'd0;
        if (vcount_q == V_LAST) begin
          vcount_d      = 10'd0;
          frame_start_d = 1'b1;
        end else begin
          vcount_d = vcount_q + 10'd1;
        end
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
    hsync_d    = !((hcount_d >= HS_START) && (hcount_d < HS_END));
    vsync_d    = !((vcount_d >= VS_START) && (vcount_d < VS_END));
    video_on_d = (hcount_d < H_VIS_END) && (vcount_d < V_VIS_END);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 800-pixel lines, shortened 13-line frame.
module tb_vga_timing_gen;

`ifdef VGA_PIX_DIV_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif
  localparam int HT    = 800;
  localparam int VT    = 13;
  localparam int FRAME = HT * VT * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pix_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;

  int checks = 0;
  int errors = 0;
  int t = 0;
  int hs_low, vs_low, vis_bad, fs_cnt, guard;

  vga_timing_gen #(
    .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_VISIBLE(6),   .V_FRONT(2),  .V_SYNC(2),  .V_BACK(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pix_tick(pix_tick),
    .hcount(hcount),
    .vcount(vcount),
    .hsync(hsync),
    .vsync(vsync),
    .video_on(video_on),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    t++;
    #1;
  endtask

  task automatic adv(input int target);
    while (t < target) step();
  endtask

  // Clock count after release at which state (h,v) first appears.
  function automatic int at(input int h, input int v);
    return (v * HT + h) * DIV;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hcount", 32'(hcount), 0);
    chk("rst_vcount", 32'(vcount), 0);
    chk("rst_hsync", 32'(hsync), 1);
    chk("rst_vsync", 32'(vsync), 1);
    chk("rst_video_on", 32'(video_on), 0);
    chk("rst_frame_start", 32'(frame_start), 0);
    chk("rst_pix_tick", 32'(pix_tick), 0);

    reset = 1'b1;
    t = 0;
    #1;
    chk("release_pix_tick", 32'(pix_tick), (DIV == 1) ? 1 : 0);
`ifdef VGA_PIX_DIV_EN
    step();
    chk("div_tick_1", 32'(pix_tick), 1);
    chk("div_hcount_1", 32'(hcount), 0);
    step();
    chk("div_tick_2", 32'(pix_tick), 0);
    chk("div_hcount_2", 32'(hcount), 1);
    step();
    chk("div_tick_3", 32'(pix_tick), 1);
`endif
    adv(at(1, 0));
    chk("first_hcount", 32'(hcount), 1);
    chk("first_vcount", 32'(vcount), 0);
    chk("first_video_on", 32'(video_on), 1);

    adv(at(639, 0));
    chk("vis_last_pixel", 32'(video_on), 1);
    adv(at(640, 0));
    chk("h640_hcount", 32'(hcount), 640);
    chk("h640_video_off", 32'(video_on), 0);
    adv(at(655, 0));
    chk("hsync_655", 32'(hsync), 1);
    adv(at(656, 0));
    chk("hsync_656", 32'(hsync), 0);
    adv(at(751, 0));
    chk("hsync_751", 32'(hsync), 0);
    adv(at(752, 0));
    chk("hsync_752", 32'(hsync), 1);
    adv(at(799, 0));
    chk("h799_vcount", 32'(vcount), 0);
    adv(at(0, 1));
    chk("line_wrap_t", t, 800 * DIV);
    chk("line_wrap_hcount", 32'(hcount), 0);
    chk("line_wrap_vcount", 32'(vcount), 1);

    hs_low = 0;
    repeat (HT * DIV) begin
      if (!hsync) hs_low++;
      step();
    end
    chk("hsync_low_clks", hs_low, 96 * DIV);

    vs_low = 0;
    vis_bad = 0;
    fs_cnt = 0;
    while (t < FRAME) begin
      if (!vsync) vs_low++;
      if (video_on && (vcount >= 10'd6)) vis_bad++;
      if (frame_start) fs_cnt++;
      if (t == at(0, 5)) chk("video_on_v5", 32'(video_on), 1);
      if (t == at(0, 6)) chk("video_off_v6", 32'(video_on), 0);
      if (t == at(799, 7)) chk("vsync_v7", 32'(vsync), 1);
      if (t == at(0, 8)) chk("vsync_v8", 32'(vsync), 0);
      if (t == at(799, 9)) chk("vsync_v9", 32'(vsync), 0);
      if (t == at(0, 10)) chk("vsync_v10", 32'(vsync), 1);
      step();
    end
    chk("vsync_low_clks", vs_low, 1600 * DIV);
    chk("video_on_blank_rows", vis_bad, 0);
    chk("no_early_frame_start", fs_cnt, 0);

    chk("wrap_frame_start", 32'(frame_start), 1);
    chk("wrap_hcount", 32'(hcount), 0);
    chk("wrap_vcount", 32'(vcount), 0);
    chk("wrap_video_on", 32'(video_on), 1);
    step();
    chk("frame_start_one_clk", 32'(frame_start), 0);

    guard = 0;
    while (!frame_start && (guard < FRAME + 10)) begin
      step();
      guard++;
    end
    chk("frame_period", t - FRAME, FRAME);

    adv(2 * FRAME + at(700, 4));
    chk("mid_hcount", 32'(hcount), 700);
    chk("mid_vcount", 32'(vcount), 4);
    chk("mid_hsync", 32'(hsync), 0);
    reset = 1'b0;
    #1;
    chk("async_hcount", 32'(hcount), 0);
    chk("async_vcount", 32'(vcount), 0);
    chk("async_hsync", 32'(hsync), 1);
    chk("async_vsync", 32'(vsync), 1);
    chk("async_video_on", 32'(video_on), 0);
    chk("async_frame_start", 32'(frame_start), 0);
    chk("async_pix_tick", 32'(pix_tick), 0);

    @(posedge clk);
    #1;
    reset = 1'b1;
    t = 0;
    adv(at(1, 0));
    chk("restart_hcount", 32'(hcount), 1);
    chk("restart_vcount", 32'(vcount), 0);
    chk("restart_video_on", 32'(video_on), 1);
    fs_cnt = 0;
    repeat (20 * DIV) begin
      if (frame_start) fs_cnt++;
      step();
    end
    chk("restart_no_frame_start", fs_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
